// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the key_debounce_ms slice.
// Holds the channel state encoding, counter sizing and parameter checks.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_e;

    // Smallest counter width able to hold the value long_ms.
    function automatic int cnt_w_min(input int long_ms);
        return $clog2(long_ms + 1);
    endfunction

    function automatic logic params_ok(
        input int deb_ms,
        input int long_ms,
        input int cnt_w
    );
        return (deb_ms >= 1)
            && (long_ms > deb_ms)
            && (cnt_w >= cnt_w_min(long_ms))
            && (cnt_w <= 31);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key channel: 2-FF sync, 4-state FSM, debounce/hold counters.
// Ports: clk, RST_N, tick_1ms enable, key_n raw active-low input;
// key_level/key_press/key_release/key_long registered outputs.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int CNT_W       = 10
) (
    input  logic clk,
    input  logic RST_N,
    input  logic tick_1ms,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_MS);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_MS);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [1:0]       sync_q, sync_d;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;

    logic             k;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hold_inc;

    assign k        = ~sync_q[1];
    assign cnt_inc  = cnt_q + ONE;
    assign hold_inc = hold_q + ONE;

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            sync_q    <= 2'b11;
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    // An input change always takes priority over a coincident tick.
    always_comb begin
        sync_d    = {sync_q[0], key_n};
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        unique case (state_q)
            ST_RELEASED: begin
                if (k) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!k) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (tick_1ms) begin
                    if (cnt_inc == DEB_LAST) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_PRESSED: begin
                if (!k) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (tick_1ms && (hold_q != LONG_MAX)) begin
                    // Saturation at LONG_MAX makes the long pulse one-shot.
                    hold_d = hold_inc;
                    long_d = (hold_inc == LONG_MAX);
                end
            end
            ST_RELEASE_WAIT: begin
                if (k) begin
                    // Bounce back: hold count kept so long-press is not re-armed.
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (tick_1ms) begin
                    if (cnt_inc == DEB_LAST) begin
                        state_d   = ST_RELEASED;
                        cnt_d     = '0;
                        hold_d    = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
                hold_d  = '0;
            end
        endcase

        level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

// File: rtl/key_debounce_ms.sv
// Multi-channel push-button debouncer driven by a 1 ms tick enable.
// Ports: clk, RST_N, tick_1ms, key_n[N_KEYS]; per-key level/press/release/long.
module key_debounce_ms
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS      = 4,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int CNT_W       = 10
) (
    input  logic              clk,
    input  logic              RST_N,
    input  logic              tick_1ms,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    if (!params_ok(DEBOUNCE_MS, LONG_MS, CNT_W)) begin : g_param_err
        $error("key_debounce_ms: illegal DEBOUNCE_MS/LONG_MS/CNT_W");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk         (clk),
            .RST_N       (RST_N),
            .tick_1ms    (tick_1ms),
            .key_n       (key_n[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i])
        );
    end

endmodule
